cal_avg_readout: RTL and testbench
==================================

# cal_avg_readout

Drains the calibrator average-data FIFO, a 32-bit, 512-deep synchronous FIFO. The FIFO is non-FWFT, with 2-cycle read latency and empty/full stop. The block emits the data as framed packets on a valid/ready stream toward the telemetry/SPI link. Each packet is one header word, LEN data words, and one checksum trailer word. A 4-entry credit-managed output buffer absorbs the FIFO read latency, so backpressure never loses or duplicates words.

## Interface
- DATA_W, 32, FIFO and stream word width
- LEN_W, 10, width of LEN; must be ≤16
- HEADER_ID, 8'hCA, packet-type tag in header bits [31:24]
- RD_LAT, 2, cycles from FIFO_RE to valid FIFO_Q
- TIMEOUT, 1024, consecutive empty cycles before underrun padding starts
- CLK  in  1  single clock, rising edge
- RESET_N  in  1  reset, synchronous, active-low
- START  in  1  one-cycle request to send one packet; honoured only in IDLE
- LEN  in  LEN_W  data word count, sampled on the accepted START
- BUSY  out  1  high from the cycle after an accepted START until DONE
- DONE  out  1  one-cycle pulse after the trailer has been accepted
- ERR_UNDERRUN  out  1  sticky; set on timeout, cleared by the next accepted START
- FIFO_RE  out  1  FIFO read enable, active-high
- FIFO_EMPTY  in  1  FIFO empty flag
- FIFO_Q  in  DATA_W  FIFO read data
- OUT_DATA  out  DATA_W  stream data
- OUT_VALID  out  1  stream valid
- OUT_READY  in  1  stream ready
- OUT_LAST  out  1  marks the trailer word

## Operation
- FSM states:
  - IDLE → HDR on START.
  - HDR → READ after pushing the header.
  - READ → TRL when all LEN words have been issued and in-flight = 0.
  - TRL → DRAIN after pushing the trailer.
  - DRAIN → IDLE when the buffer is empty, pulsing DONE.
- Header word = {HEADER_ID, SEQ[7:0], LEN zero-extended to 16}.
  - SEQ is an 8-bit packet counter, incremented at DONE, wraps 255→0.
- Output buffer: 4-entry FIFO of {last, data}.
  - OUT_* always reflects the buffer head.
  - A pop occurs on OUT_VALID & OUT_READY.
- Read issue rule: FIFO_RE = (state==READ) & (remaining>0) & !FIFO_EMPTY & (occupancy + in_flight < 4).
  - in_flight counts REs whose data has not yet been captured; range 0..RD_LAT.
- Capture: FIFO_Q is pushed into the buffer exactly RD_LAT cycles after each FIFO_RE, tracked with a RD_LAT-deep valid shift register.
- Checksum: 32-bit sum mod 2^32 of all data words, including pad words. It is cleared at START and pushed as the trailer with last=1.
- Underrun: in READ, if remaining>0 and FIFO_EMPTY holds for TIMEOUT consecutive cycles:
  - ERR_UNDERRUN sets.
  - Every remaining word is pushed as 32'hDEADBEEF, one per cycle while the buffer has room, with no FIFO_RE.
  - The packet length stays 2+LEN.
- LEN=0: header then trailer (checksum 0), no FIFO reads.
- START while not IDLE is ignored; LEN is not resampled.
- HDR and TRL pushes wait until occupancy + in_flight < 4.

## Timing
- Reset (RESET_N low at a rising edge):
  - FSM → IDLE; buffer, in-flight pipe, counters, SEQ and checksum cleared.
  - All outputs 0: FIFO_RE, OUT_VALID, OUT_LAST, OUT_DATA, BUSY, DONE, ERR_UNDERRUN.
  - Mid-packet reset silently abandons the packet; data already read from the FIFO is discarded.
- START at cycle 0 (IDLE):
  - BUSY=1 at cycle 1; the header is pushed in cycle 1 and OUT_VALID=1 at cycle 2.
  - First FIFO_RE at cycle 2 at the earliest; that word appears on OUT_DATA at cycle 5 at the earliest.
- Throughput: with OUT_READY=1 and the FIFO non-empty, FIFO_RE and OUT_VALID&OUT_READY sustain 1 word/cycle.
- Stalls:
  - OUT_READY low: FIFO_RE stops once occupancy + in_flight = 4.
  - Data in flight is always captured; the buffer never overflows.
- OUT_DATA/OUT_LAST stay stable while OUT_VALID & !OUT_READY.
- DONE is asserted the cycle after the trailer handshake; BUSY falls in the same cycle as DONE.
- A new START is accepted in the cycle after DONE.

## Test plan
- FIFO preloaded with 1..8, START with LEN=8, OUT_READY=1:
  - Stream = 0xCA000008, 1..8, trailer 0x00000024 with OUT_LAST.
  - Exactly 8 FIFO_RE pulses; DONE once; SEQ=1 afterwards.
- Same data, OUT_READY toggled randomly at 30% duty:
  - Identical word sequence and checksum; no drops or duplicates.
  - The buffer never exceeds 4 entries (assertion).
- LEN=0: stream = 0xCA010000, then 0x00000000 with last; FIFO_RE never asserted.
- FIFO holds 3 words, LEN=5, TIMEOUT=16:
  - 3 data words, then 2 × 0xDEADBEEF, then trailer = sum.
  - ERR_UNDERRUN=1 until the next START.
- RESET_N low for 1 cycle mid-READ:
  - All outputs 0 the next cycle; SEQ=0.
  - A following START yields header 0xCA00xxxx.
- START pulsed during BUSY: ignored, with no second packet and no LEN change. SEQ wraps 255→0 over 256 packets.

Source files
------------

// File: rtl/cal_avg_readout.sv
// Drains the calibrator average FIFO into framed packets (header, LEN words, checksum trailer)
// on a valid/ready stream; a 4-entry buffer absorbs the FIFO read latency under backpressure.
module cal_avg_readout #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LEN_W     = 10,
    parameter logic [7:0]  HEADER_ID = 8'hCA,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_underrun_o,
    output logic              fifo_re_o,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_q_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_last_o
);
    localparam int unsigned       TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [DATA_W-1:0] PAD_WORD = DATA_W'(32'hDEADBEEF);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_READ, S_TRL, S_DRAIN} state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [7:0]        seq_q, seq_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic              err_q, err_d;
    logic              pad_q, pad_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [RD_LAT-1:0] pipe_q, pipe_d;

    logic [DATA_W:0]   buf_q [4];
    logic [1:0]        wr_ptr_q, rd_ptr_q;
    logic [2:0]        cnt_q, cnt_d;

    logic [3:0]        in_flight;
    logic              has_room;
    logic              push;
    logic              pop;
    logic              pad_push;
    logic [DATA_W:0]   push_word;
    logic [DATA_W:0]   head;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            in_flight = in_flight + 4'(pipe_q[i]);
        end
    end

    // Room counts reads still in flight so every issued read has a guaranteed slot.
    assign has_room       = ({1'b0, cnt_q} + in_flight) < 4'd4;
    assign head           = buf_q[rd_ptr_q];
    assign out_valid_o    = (cnt_q != 3'd0);
    assign out_data_o     = out_valid_o ? head[DATA_W-1:0] : '0;
    assign out_last_o     = out_valid_o & head[DATA_W];
    assign pop            = out_valid_o & out_ready_i;
    assign fifo_re_o      = (state_q == S_READ) && (rem_q != '0) && !pad_q && !fifo_empty_i && has_room;
    assign pad_push       = (state_q == S_READ) && pad_q && (rem_q != '0) && has_room && (in_flight == 4'd0);
    assign done_o         = (state_q == S_DRAIN) && (cnt_q == 3'd0);
    assign busy_o         = (state_q != S_IDLE) && !done_o;
    assign err_underrun_o = err_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d   = state_q;
        len_d     = len_q;
        rem_d     = rem_q;
        seq_d     = seq_q;
        csum_d    = csum_q;
        err_d     = err_q;
        pad_d     = pad_q;
        to_cnt_d  = to_cnt_q;
        push      = 1'b0;
        push_word = '0;
        pipe_d    = pipe_q << 1;
        pipe_d[0] = fifo_re_o;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_HDR;
                    len_d    = len_i;
                    rem_d    = len_i;
                    csum_d   = '0;
                    err_d    = 1'b0;
                    pad_d    = 1'b0;
                    to_cnt_d = '0;
                end
            end
            S_HDR: begin
                if (has_room) begin
                    push      = 1'b1;
                    push_word = {1'b0, DATA_W'({HEADER_ID, seq_q, 16'(len_q)})};
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                if (pipe_q[RD_LAT-1]) begin
                    push      = 1'b1;
                    push_word = {1'b0, fifo_q_i};
                    csum_d    = csum_q + fifo_q_i;
                end else if (pad_push) begin
                    push      = 1'b1;
                    push_word = {1'b0, PAD_WORD};
                    csum_d    = csum_q + PAD_WORD;
                end
                if (fifo_re_o || pad_push) begin
                    rem_d = rem_q - LEN_W'(1);
                end
                // Starvation watchdog: only consecutive empty cycles count.
                if ((rem_q != '0) && !pad_q) begin
                    if (!fifo_empty_i) begin
                        to_cnt_d = '0;
                    end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        pad_d    = 1'b1;
                        err_d    = 1'b1;
                        to_cnt_d = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
                if ((rem_q == '0) && (in_flight == 4'd0)) begin
                    state_d = S_TRL;
                end
            end
            S_TRL: begin
                if (has_room) begin
                    push      = 1'b1;
                    push_word = {1'b1, csum_q};
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_IDLE;
                    seq_d   = seq_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 3'd1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            rem_q    <= '0;
            seq_q    <= '0;
            csum_q   <= '0;
            err_q    <= 1'b0;
            pad_q    <= 1'b0;
            to_cnt_q <= '0;
            pipe_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            rem_q    <= rem_d;
            seq_q    <= seq_d;
            csum_q   <= csum_d;
            err_q    <= err_d;
            pad_q    <= pad_d;
            to_cnt_q <= to_cnt_d;
            pipe_q   <= pipe_d;
            cnt_q    <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
        end
    end

    // NOTE: buffer storage is not reset; the head is gated by occupancy, so stale entries never reach the outputs.
    always_ff @(posedge clk_i) begin
        if (push) buf_q[wr_ptr_q] <= push_word;
    end

endmodule

// File: tb/tb_cal_avg_readout.sv
// Directed bench for cal_avg_readout: framing, latency, backpressure, underrun padding,
// ignored START, mid-packet reset and SEQ wrap, against hand-computed streams.
module tb_cal_avg_readout;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  len;
    logic        busy, done, err, fifo_re, fifo_empty;
    logic [31:0] fifo_q;
    logic [31:0] out_data;
    logic        out_valid, out_ready, out_last;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cal_avg_readout #(.TIMEOUT(16)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .len_i(len),
        .busy_o(busy), .done_o(done), .err_underrun_o(err),
        .fifo_re_o(fifo_re), .fifo_empty_i(fifo_empty), .fifo_q_i(fifo_q),
        .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_last_o(out_last)
    );

    // Source FIFO model: non-FWFT, data valid two cycles after the read enable.
    logic [31:0] fmem [0:1023];
    int          wr_idx = 0;
    int          rd_idx = 0;
    int          re_cnt = 0;
    int          rd_err = 0;
    logic [31:0] f_s1 = '0;
    assign fifo_empty = (wr_idx == rd_idx);
    initial fifo_q = '0;

    always @(posedge clk) begin
        if (fifo_re === 1'b1) begin
            re_cnt++;
            if (wr_idx == rd_idx) rd_err++;
            else begin
                f_s1   <= fmem[rd_idx % 1024];
                rd_idx <= rd_idx + 1;
            end
        end
        fifo_q <= f_s1;
    end

    task automatic fifo_load(input logic [31:0] w);
        fmem[wr_idx % 1024] = w;
        wr_idx++;
    endtask

    // Sink: 0 = ready low, 1 = ready high, 2 = ready high 30% of cycles.
    int rdy_mode = 0;
    always @(negedge clk) begin
        case (rdy_mode)
            1:       out_ready = 1'b1;
            2:       out_ready = ($urandom_range(0, 9) < 3);
            default: out_ready = 1'b0;
        endcase
    end

    // Stream monitor and invariants.
    logic [32:0] cap_q [$];
    int          done_cnt = 0;
    int          stab_err = 0;
    int          ovf_err  = 0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_word  = '0;

    always @(posedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) cap_q.push_back({out_last, out_data});
        if (done === 1'b1) done_cnt++;
        if (prev_stall && (out_valid !== 1'b1 || {out_last, out_data} !== prev_word)) stab_err++;
        prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0) && (rst_n === 1'b1);
        prev_word  = {out_last, out_data};
        if (dut.cnt_q > 3'd4) ovf_err++;
    end

    task automatic start_pkt(input logic [9:0] l);
        @(negedge clk);
        len   = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            ok = (done === 1'b1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; len = '0; rdy_mode = 0;
        repeat (3) @(negedge clk);
        n_checks++; if (fifo_re !== 1'b0)    $display("FAIL reset_fifo_re: got %b exp 0", fifo_re);      else n_pass++;
        n_checks++; if (out_valid !== 1'b0)  $display("FAIL reset_out_valid: got %b exp 0", out_valid);  else n_pass++;
        n_checks++; if (out_last !== 1'b0)   $display("FAIL reset_out_last: got %b exp 0", out_last);    else n_pass++;
        n_checks++; if (out_data !== 32'h0)  $display("FAIL reset_out_data: got %h exp 0", out_data);    else n_pass++;
        n_checks++; if (busy !== 1'b0)       $display("FAIL reset_busy: got %b exp 0", busy);            else n_pass++;
        n_checks++; if (done !== 1'b0)       $display("FAIL reset_done: got %b exp 0", done);            else n_pass++;
        n_checks++; if (err !== 1'b0)        $display("FAIL reset_err: got %b exp 0", err);              else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [32:0] exp [$];
        int base, re_base, done_base;
        bit ok;
        for (int k = 1; k <= 8; k++) fifo_load(32'(k));
        rdy_mode = 1;
        repeat (3) @(negedge clk);
        base = cap_q.size(); re_base = re_cnt; done_base = done_cnt;
        len = 10'd8; start = 1'b1;                  // cycle 0
        @(negedge clk); start = 1'b0;              // cycle 1
        n_checks++; if (busy !== 1'b1)      $display("FAIL basic_busy_c1: got %b exp 1", busy);           else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_valid_c1: got %b exp 0", out_valid);     else n_pass++;
        @(negedge clk);                             // cycle 2
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hCA000008)
            $display("FAIL basic_header_c2: got v=%b %h exp v=1 ca000008", out_valid, out_data); else n_pass++;
        n_checks++; if (fifo_re !== 1'b1)   $display("FAIL basic_first_re_c2: got %b exp 1", fifo_re);    else n_pass++;
        repeat (3) @(negedge clk);                  // cycle 5
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h1)
            $display("FAIL basic_first_word_c5: got v=%b %h exp v=1 00000001", out_valid, out_data); else n_pass++;
        wait_done(200, ok);
        n_checks++; if (!ok) $display("FAIL basic_done_timeout: got no DONE exp DONE within 200 cycles"); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_at_done: got %b exp 0", busy); else n_pass++;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b exp 0", done); else n_pass++;
        exp.push_back({1'b0, 32'hCA000008});
        for (int k = 1; k <= 8; k++) exp.push_back({1'b0, 32'(k)});
        exp.push_back({1'b1, 32'h00000024});
        n_checks++; if (cap_q.size() - base != exp.size())
            $display("FAIL basic_count: got %0d exp %0d", cap_q.size() - base, exp.size()); else n_pass++;
        for (int i = 0; i < exp.size(); i++) begin
            logic [32:0] got;
            got = (base + i < cap_q.size()) ? cap_q[base + i] : 'x;
            n_checks++; if (got !== exp[i]) $display("FAIL basic_word%0d: got %h exp %h", i, got, exp[i]); else n_pass++;
        end
        n_checks++; if (re_cnt - re_base != 8) $display("FAIL basic_re_count: got %0d exp 8", re_cnt - re_base); else n_pass++;
        n_checks++; if (done_cnt - done_base != 1) $display("FAIL basic_done_count: got %0d exp 1", done_cnt - done_base); else n_pass++;
    endtask

    task automatic test_len_zero();
        int base, re_base;
        bit ok;
        logic [32:0] got0, got1;
        base = cap_q.size(); re_base = re_cnt;
        start_pkt(10'd0);
        wait_done(100, ok);
        n_checks++; if (!ok) $display("FAIL len0_done_timeout: got no DONE exp DONE within 100 cycles"); else n_pass++;
        n_checks++; if (cap_q.size() - base != 2) $display("FAIL len0_count: got %0d exp 2", cap_q.size() - base); else n_pass++;
        got0 = (base < cap_q.size())     ? cap_q[base]     : 'x;
        got1 = (base + 1 < cap_q.size()) ? cap_q[base + 1] : 'x;
        n_checks++; if (got0 !== {1'b0, 32'hCA010000}) $display("FAIL len0_header: got %h exp 0ca010000", got0); else n_pass++;
        n_checks++; if (got1 !== {1'b1, 32'h0})        $display("FAIL len0_trailer: got %h exp 100000000", got1); else n_pass++;
        n_checks++; if (re_cnt != re_base) $display("FAIL len0_no_reads: got %0d exp 0", re_cnt - re_base); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [32:0] exp [$];
        int base, re_base;
        bit ok;
        for (int k = 1; k <= 8; k++) fifo_load(32'(k));
        base = cap_q.size(); re_base = re_cnt;
        rdy_mode = 2;
        start_pkt(10'd8);
        wait_done(2000, ok);
        rdy_mode = 1;
        n_checks++; if (!ok) $display("FAIL bp_done_timeout: got no DONE exp DONE within 2000 cycles"); else n_pass++;
        exp.push_back({1'b0, 32'hCA020008});
        for (int k = 1; k <= 8; k++) exp.push_back({1'b0, 32'(k)});
        exp.push_back({1'b1, 32'h00000024});
        n_checks++; if (cap_q.size() - base != exp.size())
            $display("FAIL bp_count: got %0d exp %0d", cap_q.size() - base, exp.size()); else n_pass++;
        for (int i = 0; i < exp.size(); i++) begin
            logic [32:0] got;
            got = (base + i < cap_q.size()) ? cap_q[base + i] : 'x;
            n_checks++; if (got !== exp[i]) $display("FAIL bp_word%0d: got %h exp %h", i, got, exp[i]); else n_pass++;
        end
        n_checks++; if (re_cnt - re_base != 8) $display("FAIL bp_re_count: got %0d exp 8", re_cnt - re_base); else n_pass++;
        n_checks++; if (stab_err != 0) $display("FAIL bp_stable_while_stalled: got %0d violations exp 0", stab_err); else n_pass++;
        n_checks++; if (ovf_err != 0) $display("FAIL bp_buffer_overflow: got %0d violations exp 0", ovf_err); else n_pass++;
    endtask

    task automatic test_underrun();
        logic [32:0] exp [$];
        int base, re_base;
        bit ok;
        fifo_load(32'h11111111); fifo_load(32'h22222222); fifo_load(32'h33333333);
        base = cap_q.size(); re_base = re_cnt;
        start_pkt(10'd5);
        wait_done(500, ok);
        n_checks++; if (!ok) $display("FAIL underrun_done_timeout: got no DONE exp DONE within 500 cycles"); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL underrun_err_set: got %b exp 1", err); else n_pass++;
        exp.push_back({1'b0, 32'hCA030005});
        exp.push_back({1'b0, 32'h11111111});
        exp.push_back({1'b0, 32'h22222222});
        exp.push_back({1'b0, 32'h33333333});
        exp.push_back({1'b0, 32'hDEADBEEF});
        exp.push_back({1'b0, 32'hDEADBEEF});
        exp.push_back({1'b1, 32'h23C1E444});
        n_checks++; if (cap_q.size() - base != exp.size())
            $display("FAIL underrun_count: got %0d exp %0d", cap_q.size() - base, exp.size()); else n_pass++;
        for (int i = 0; i < exp.size(); i++) begin
            logic [32:0] got;
            got = (base + i < cap_q.size()) ? cap_q[base + i] : 'x;
            n_checks++; if (got !== exp[i]) $display("FAIL underrun_word%0d: got %h exp %h", i, got, exp[i]); else n_pass++;
        end
        n_checks++; if (re_cnt - re_base != 3) $display("FAIL underrun_re_count: got %0d exp 3", re_cnt - re_base); else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++; if (err !== 1'b1) $display("FAIL underrun_err_sticky: got %b exp 1", err); else n_pass++;
    endtask

    task automatic test_start_ignored();
        logic [32:0] exp [$];
        int base, done_base;
        bit ok;
        for (int k = 1; k <= 4; k++) fifo_load(32'(k));
        base = cap_q.size(); done_base = done_cnt;
        @(negedge clk); len = 10'd4; start = 1'b1;  // cycle 0
        @(negedge clk); start = 1'b0;              // cycle 1
        n_checks++; if (err !== 1'b0)  $display("FAIL ign_err_cleared: got %b exp 0", err); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL ign_busy: got %b exp 1", busy); else n_pass++;
        len = 10'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(200, ok);
        n_checks++; if (!ok) $display("FAIL ign_done_timeout: got no DONE exp DONE within 200 cycles"); else n_pass++;
        exp.push_back({1'b0, 32'hCA040004});
        for (int k = 1; k <= 4; k++) exp.push_back({1'b0, 32'(k)});
        exp.push_back({1'b1, 32'h0000000A});
        for (int i = 0; i < exp.size(); i++) begin
            logic [32:0] got;
            got = (base + i < cap_q.size()) ? cap_q[base + i] : 'x;
            n_checks++; if (got !== exp[i]) $display("FAIL ign_word%0d: got %h exp %h", i, got, exp[i]); else n_pass++;
        end
        repeat (20) @(negedge clk);
        n_checks++; if (cap_q.size() - base != exp.size())
            $display("FAIL ign_no_second_packet: got %0d words exp %0d", cap_q.size() - base, exp.size()); else n_pass++;
        n_checks++; if (done_cnt - done_base != 1) $display("FAIL ign_done_count: got %0d exp 1", done_cnt - done_base); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL ign_idle_after: got busy=%b exp 0", busy); else n_pass++;
    endtask

    task automatic test_mid_reset();
        int base;
        bit ok;
        logic [32:0] got0, got1;
        for (int k = 1; k <= 8; k++) fifo_load(32'(k));
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        start_pkt(10'd8);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if ({fifo_re, out_valid, out_last, busy, done, err} !== 6'b0)
            $display("FAIL midrst_flags: got re/v/last/busy/done/err=%b exp 000000", {fifo_re, out_valid, out_last, busy, done, err}); else n_pass++;
        n_checks++; if (out_data !== 32'h0) $display("FAIL midrst_out_data: got %h exp 0", out_data); else n_pass++;
        rst_n = 1'b1;
        wr_idx = rd_idx;
        rdy_mode = 1;
        repeat (3) @(negedge clk);
        base = cap_q.size();
        start_pkt(10'd0);
        wait_done(100, ok);
        n_checks++; if (!ok) $display("FAIL midrst_done_timeout: got no DONE exp DONE within 100 cycles"); else n_pass++;
        got0 = (base < cap_q.size())     ? cap_q[base]     : 'x;
        got1 = (base + 1 < cap_q.size()) ? cap_q[base + 1] : 'x;
        n_checks++; if (got0 !== {1'b0, 32'hCA000000}) $display("FAIL midrst_seq_cleared: got %h exp 0ca000000", got0); else n_pass++;
        n_checks++; if (got1 !== {1'b1, 32'h0})        $display("FAIL midrst_trailer: got %h exp 100000000", got1); else n_pass++;
    endtask

    task automatic test_seq_wrap();
        int base;
        bit ok;
        logic [32:0] got, want;
        for (int i = 1; i <= 256; i++) begin
            base = cap_q.size();
            start_pkt(10'd0);
            wait_done(50, ok);
            n_checks++; if (!ok) $display("FAIL wrap_done_timeout_pkt%0d: got no DONE exp DONE within 50 cycles", i); else n_pass++;
            got  = (base < cap_q.size()) ? cap_q[base] : 'x;
            want = {1'b0, 8'hCA, 8'(i), 16'h0000};
            n_checks++; if (got !== want) $display("FAIL wrap_header_pkt%0d: got %h exp %h", i, got, want); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_backpressure();
        test_underrun();
        test_start_ignored();
        test_mid_reset();
        test_seq_wrap();
        n_checks++; if (rd_err != 0)   $display("FAIL read_while_empty: got %0d exp 0", rd_err); else n_pass++;
        n_checks++; if (stab_err != 0) $display("FAIL stable_while_stalled: got %0d exp 0", stab_err); else n_pass++;
        n_checks++; if (ovf_err != 0)  $display("FAIL buffer_overflow: got %0d exp 0", ovf_err); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish exp finish before 2 ms");
        $fatal(1, "simulation time limit reached");
    end
endmodule
